// File: rtl/block_stream_emitter.sv
// block_stream_emitter: serialises BEGIN/END/WORD/SPACE commands into a space-separated ASCII stream; BLOCK_EMITTER_UPPERCASE_EN selects uppercase keywords
module block_stream_emitter #(
  parameter int DEPTH_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  output logic               cmd_ready,
  output logic [7:0]         out_char,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DEPTH_W-1:0] depth,
  output logic               err,
  output logic               balanced
);
  localparam logic IDLE = 1'b0;
  localparam logic EMIT = 1'b1;
  localparam logic [1:0] C_BEGIN = 2'd0;
  localparam logic [1:0] C_END   = 2'd1;
  localparam logic [1:0] C_WORD  = 2'd2;
  localparam logic [DEPTH_W-1:0] ONE = 1;
  // Words are left-aligned so byte 5 is always the first character.
`ifdef BLOCK_EMITTER_UPPERCASE_EN
  localparam logic [47:0] S_BEGIN = "BEGIN ";
  localparam logic [47:0] S_END   = {"END ", 16'h0};
  localparam logic [47:0] S_WORD  = {"X ", 32'h0};
`else
  localparam logic [47:0] S_BEGIN = "begin ";
  localparam logic [47:0] S_END   = {"end ", 16'h0};
  localparam logic [47:0] S_WORD  = {"x ", 32'h0};
`endif
  localparam logic [47:0] S_SPACE = {8'h20, 40'h0};

  logic               state_q, state_d;
  logic [1:0]         cmd_q, cmd_d;
  logic [2:0]         idx_q, idx_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_q, err_d;
  logic               accept, illegal, last, good;
  logic [2:0]         len;
  logic [5:0][7:0]    rom;

  // Character ROM and word length selected by the latched command.
  always_comb begin
    rom = cmd_q == C_BEGIN ? S_BEGIN : cmd_q == C_END ? S_END : cmd_q == C_WORD ? S_WORD : S_SPACE;
    len = cmd_q == C_BEGIN ? 3'd6 : cmd_q == C_END ? 3'd4 : cmd_q == C_WORD ? 3'd2 : 3'd1;
    last = idx_q == len - 3'd1;
  end

  // Acceptance, legality and next-state; depth moves at acceptance, not at end of emission.
  always_comb begin
    accept  = cmd_valid && state_q == IDLE;
    illegal = (cmd == C_END && depth_q == '0) || (cmd == C_BEGIN && depth_q == '1);
    good    = accept && !illegal;
    state_d = state_q == IDLE ? (good ? EMIT : IDLE) : (out_ready && last ? IDLE : EMIT);
    cmd_d   = accept ? cmd : cmd_q;
    idx_d   = state_q == IDLE ? 3'd0 : out_ready ? (last ? 3'd0 : idx_q + 3'd1) : idx_q;
    depth_d = good && cmd == C_BEGIN ? depth_q + ONE : good && cmd == C_END ? depth_q - ONE : depth_q;
    err_d   = err_q || (accept && illegal);
  end

  // State registers, cleared asynchronously so a partial word is abandoned at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= 2'd0;
      idx_q   <= 3'd0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = state_q == IDLE;
  assign out_valid = state_q == EMIT;
  assign out_char  = state_q == EMIT ? rom[3'd5 - idx_q] : 8'h00;
  assign depth     = depth_q;
  assign err       = err_q;
  assign balanced  = depth_q == '0 && !err_q;
endmodule

// File: tb/tb_block_stream_emitter.sv
// tb_block_stream_emitter: directed and random checks of block_stream_emitter against a byte-queue model
module tb_block_stream_emitter;
  localparam int DW = 2;
  localparam int MAXD = (1 << DW) - 1;

  logic          clk, reset, cmd_valid, cmd_ready, out_valid, out_ready, err, balanced;
  logic [1:0]    cmd;
  logic [7:0]    out_char;
  logic [DW-1:0] depth;

  int vectors = 0;
  int miscompares = 0;

  byte   mq[$];
  int    m_depth, m_hs;
  bit    m_err;
  string m_stream;
  string w[4];

  block_stream_emitter #(.DEPTH_W(DW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
    .depth(depth), .err(err), .balanced(balanced)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic string cs(input string s);
`ifdef BLOCK_EMITTER_UPPERCASE_EN
    return s.toupper();
`else
    return s;
`endif
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic chks(input string n, input string a, input string e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s got=\"%s\" expected=\"%s\"", n, a, e);
    end
  endtask

  // Compare DUT against the model, then advance the model with the inputs the next edge will see.
  always @(negedge clk) begin
    if (reset) begin
      mq.delete();
      m_depth = 0;
      m_err = 0;
      m_hs = 0;
      m_stream = "";
    end
    chk("cmd_ready", cmd_ready, mq.size() == 0);
    chk("out_valid", out_valid, mq.size() != 0);
    chk("out_char", out_char, mq.size() != 0 ? mq[0] : 8'h00);
    chk("depth", depth, m_depth);
    chk("err", err, m_err);
    chk("balanced", balanced, m_depth == 0 && !m_err);
    if (!reset) begin
      if (mq.size() == 0) begin
        if (cmd_valid) begin
          if ((cmd == 2'd1 && m_depth == 0) || (cmd == 2'd0 && m_depth == MAXD)) m_err = 1;
          else begin
            m_depth += cmd == 2'd0 ? 1 : cmd == 2'd1 ? -1 : 0;
            for (int i = 0; i < w[cmd].len(); i++) mq.push_back(w[cmd][i]);
          end
        end
      end else if (out_ready) begin
        m_stream = $sformatf("%s%c", m_stream, mq[0]);
        m_hs++;
        void'(mq.pop_front());
      end
    end
  end

  task automatic do_reset();
    cmd_valid = 0;
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic issue(input logic [1:0] c);
    cmd_valid = 1;
    cmd = c;
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && !cmd_ready; i++) begin
      @(posedge clk);
      #1;
    end
    chk("idle_timeout", cmd_ready, 1);
  endtask

  initial begin
    string lit;
    w[0] = cs("begin ");
    w[1] = cs("end ");
    w[2] = cs("x ");
    w[3] = " ";
    reset = 1;
    cmd_valid = 0;
    cmd = 0;
    out_ready = 0;
    @(posedge clk);
    #1 reset = 0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_char", out_char, 8'h00);
    chk("rst_depth", depth, 0);
    chk("rst_err", err, 0);
    chk("rst_balanced", balanced, 1);

    // BEGIN at full rate: six consecutive bytes, then one bubble.
    out_ready = 1;
    lit = cs("begin ");
    issue(2'd0);
    for (int i = 0; i < 6; i++) begin
      chk("begin_valid", out_valid, 1);
      chk("begin_byte", out_char, lit[i]);
      @(posedge clk);
      #1;
    end
    chk("begin_ready_back", cmd_ready, 1);
    chk("begin_depth", depth, 1);
    chk("begin_balanced", balanced, 0);

    // BEGIN WORD END stream with depth 1,1,0.
    issue(2'd2);
    chk("word_depth", depth, 1);
    wait_idle();
    issue(2'd1);
    chk("end_depth", depth, 0);
    wait_idle();
    chks("bxe_stream", m_stream, cs("begin x end "));
    chk("bxe_balanced", balanced, 1);
    chk("bxe_err", err, 0);

    // Illegal END from reset.
    do_reset();
    issue(2'd1);
    chk("ill_end_valid", out_valid, 0);
    chk("ill_end_ready", cmd_ready, 1);
    chk("ill_end_err", err, 1);
    chk("ill_end_depth", depth, 0);
    chk("ill_end_bal", balanced, 0);
    issue(2'd0);
    wait_idle();
    chks("after_err_stream", m_stream, cs("begin "));
    chk("after_err_err", err, 1);
    chk("after_err_depth", depth, 1);

    // Stalled BEGIN, out_ready pattern 1,0,0.
    do_reset();
    out_ready = 0;
    issue(2'd0);
    for (int k = 0; k < 18; k++) begin
      out_ready = (k % 3) == 0;
      @(posedge clk);
      #1;
    end
    out_ready = 1;
    wait_idle();
    chk("stall_hs", m_hs, 6);
    chks("stall_stream", m_stream, cs("begin "));

    // Depth saturation at 2^DW-1.
    do_reset();
    for (int k = 0; k < MAXD; k++) begin
      issue(2'd0);
      wait_idle();
    end
    chk("full_depth", depth, MAXD);
    issue(2'd0);
    chk("ovf_valid", out_valid, 0);
    chk("ovf_err", err, 1);
    chk("ovf_depth", depth, MAXD);

    // Reset mid-word abandons it asynchronously.
    do_reset();
    issue(2'd0);
    repeat (3) @(posedge clk);
    #3 reset = 1;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_depth", depth, 0);
    chk("async_char", out_char, 8'h00);
    @(posedge clk);
    #1 reset = 0;
    chk("post_rst_ready", cmd_ready, 1);
    issue(2'd3);
    chk("space_byte", out_char, 8'h20);
    wait_idle();
    chks("space_stream", m_stream, " ");

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      cmd_valid = $urandom_range(0, 1);
      cmd = 2'($urandom_range(0, 3));
      out_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 499) == 0) reset = 1;
      @(posedge clk);
      #1 reset = 0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
